// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Latency: n/a (package).
// Backpressure: n/a (package).
package div_pkg;

   localparam int DIV_WIDTH   = 32;              // default operand width
   localparam int DIV_LATENCY = DIV_WIDTH + 2;   // accept edge to done edge
   localparam int DIV_MAX_W   = 64;              // widest operand abs_ext accepts

   typedef enum logic [1:0] {
      IDLE,
      PREP,
      ITER,
      FIX
   } div_state_t;

   // Magnitude of a sign-extended two's-complement value, one bit wider so
   // the most negative number has an exact positive magnitude.
   function automatic logic [DIV_MAX_W:0] abs_ext(input logic [DIV_MAX_W-1:0] v);
      logic [DIV_MAX_W-1:0] mag;
      mag = v[DIV_MAX_W-1] ? (~v + 1'b1) : v;
      return {1'b0, mag};
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none.
// Ports: rem_i/quo_i current partial remainder and quotient/dividend shift
//        register, dvsr_i divisor magnitude; rem_o/quo_o the values after one step.
module div_step
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH:0]   dvsr_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic           trial_ok;

   always_comb begin
      // The partial remainder never exceeds the dividend magnitude
      // (<= 2^(WIDTH-1)), so WIDTH bits hold it and the shifted value fits
      // in WIDTH+1 bits alongside the WIDTH+1-bit divisor magnitude.
      shifted  = {rem_i, quo_i[WIDTH-1]};
      // Trial subtraction is non-negative exactly when shifted >= divisor.
      trial_ok = (shifted >= dvsr_i);
      rem_o    = trial_ok ? WIDTH'(shifted - dvsr_i) : shifted[WIDTH-1:0];
      quo_o    = {quo_i[WIDTH-2:0], trial_ok};
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider; quotient on outLO, remainder on outHI.
// Latency: done pulses WIDTH+2 edges after acceptance (2 for a zero divisor with DIV_ZERO_SHORTCUT_EN).
// Backpressure: start is only sampled while busy=0; requests during busy are dropped.
// Ports: clock/reset_n (async active-low); start, dividend, divisor request;
//        busy, done (1-cycle pulse), div_zero, outLO (quotient), outHI (remainder).
// Optional macro DIV_ZERO_SHORTCUT_EN: zero divisor skips the iterations.
module seq_divider
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] outLO,
   output logic [WIDTH-1:0] outHI
);

   localparam int              CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   div_state_t       state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;          // captured dividend
   logic [WIDTH-1:0] dvs_q, dvs_d;          // captured divisor
   logic [WIDTH-1:0] quo_q, quo_d;          // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] rem_q, rem_d;          // partial remainder magnitude
   logic [WIDTH:0]   dvsr_q, dvsr_d;        // divisor magnitude
   logic             sign_quo_q, sign_quo_d;
   logic             sign_rem_q, sign_rem_d;
   logic             dz_q, dz_d;            // zero divisor for the op in flight
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] out_lo_q, out_lo_d;
   logic [WIDTH-1:0] out_hi_q, out_hi_d;
   logic             div_zero_q, div_zero_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] step_rem;
   logic [WIDTH-1:0] step_quo;

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dvsr_i (dvsr_q),
      .rem_o  (step_rem),
      .quo_o  (step_quo)
   );

   always_comb begin
      state_d    = state_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      sign_quo_d = sign_quo_q;
      sign_rem_d = sign_rem_q;
      dz_d       = dz_q;
      cnt_d      = cnt_q;
      out_lo_d   = out_lo_q;
      out_hi_d   = out_hi_q;
      div_zero_d = div_zero_q;
      done_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               dvd_d   = dividend;
               dvs_d   = divisor;
               state_d = PREP;
            end
         end

         PREP: begin
            // Operands are sign-extended to the helper's width; the
            // truncated magnitude of the dividend is exact in WIDTH bits
            // because it never exceeds 2^(WIDTH-1).
            quo_d      = WIDTH'(abs_ext(DIV_MAX_W'(signed'(dvd_q))));
            dvsr_d     = (WIDTH+1)'(abs_ext(DIV_MAX_W'(signed'(dvs_q))));
            rem_d      = '0;
            sign_quo_d = dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1];
            sign_rem_d = dvd_q[WIDTH-1];
            dz_d       = (dvs_q == '0);
            cnt_d      = CNT_INIT;
`ifdef DIV_ZERO_SHORTCUT_EN
            state_d    = (dvs_q == '0) ? FIX : ITER;
`else
            // A zero divisor still walks every iteration; FIX overrides
            // the results so nothing depends on what the steps produce.
            state_d    = ITER;
`endif
         end

         ITER: begin
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         FIX: begin
            if (dz_q) begin
               out_lo_d = '1;
               out_hi_d = dvd_q;
            end else begin
               // Negating 2^(WIDTH-1) wraps to itself, which is exactly the
               // required result for the most-negative / -1 overflow case.
               out_lo_d = sign_quo_q ? (~quo_q + 1'b1) : quo_q;
               out_hi_d = sign_rem_q ? (~rem_q + 1'b1) : rem_q;
            end
            div_zero_d = dz_q;
            done_d     = 1'b1;
            state_d    = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         dvd_q      <= '0;
         dvs_q      <= '0;
         quo_q      <= '0;
         rem_q      <= '0;
         dvsr_q     <= '0;
         sign_quo_q <= 1'b0;
         sign_rem_q <= 1'b0;
         dz_q       <= 1'b0;
         cnt_q      <= '0;
         out_lo_q   <= '0;
         out_hi_q   <= '0;
         div_zero_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         sign_quo_q <= sign_quo_d;
         sign_rem_q <= sign_rem_d;
         dz_q       <= dz_d;
         cnt_q      <= cnt_d;
         out_lo_q   <= out_lo_d;
         out_hi_q   <= out_hi_d;
         div_zero_q <= div_zero_d;
         done_q     <= done_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign outLO    = out_lo_q;
   assign outHI    = out_hi_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider with a scoreboard of expected results.
// Latency: checks done arrives 34 edges (or 2 for shortcut zero divides) after acceptance.
// Backpressure: issues a new op only in a cycle where busy=0, including the done cycle.
module tb_seq_divider;

   localparam int W        = 32;
   localparam int LAT_FULL = 34;
`ifdef DIV_ZERO_SHORTCUT_EN
   localparam int LAT_ZERO = 2;
`else
   localparam int LAT_ZERO = 34;
`endif
   localparam int NUM_RAND = 1000;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          start;
   logic [W-1:0]  dividend;
   logic [W-1:0]  divisor;
   logic          busy;
   logic          done;
   logic          div_zero;
   logic [W-1:0]  outLO;
   logic [W-1:0]  outHI;

   seq_divider #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .start    (start),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .outLO    (outLO),
      .outHI    (outHI)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           acc;
      int           lat;
   } exp_t;

   exp_t sb[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   done_cnt  = 0;
   logic [W-1:0] prev_lo = '0;
   logic [W-1:0] prev_hi = '0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   // Independent reference: SV signed division truncates toward zero and
   // gives the remainder the dividend's sign; the two special cases are
   // spelled out rather than left to simulator arithmetic.
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
      int sa, sbv;
      sa  = a;
      sbv = b;
      dz  = (b == '0);
      if (b == '0) begin
         q = '1;
         r = a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = '0;
      end else begin
         q = sa / sbv;
         r = sa % sbv;
      end
   endtask

   // Result monitor: pops one expectation per done pulse.
   always @(negedge clock) begin
      exp_t         e;
      logic [W-1:0] inv;
      if (reset_n && busy && !done) begin
         check("hold_lo", outLO, prev_lo);
         check("hold_hi", outHI, prev_hi);
      end
      if (done) begin
         done_cnt++;
         if (sb.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            e   = sb.pop_front();
            inv = outLO * e.b + outHI;
            check("quotient", outLO, e.q);
            check("remainder", outHI, e.r);
            check("div_zero", div_zero, e.dz);
            check("latency", cyc - e.acc, e.lat);
            check("invariant", inv, e.a);
            check("busy_in_done", busy, 1'b0);
         end
      end
      prev_lo = outLO;
      prev_hi = outHI;
   end

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (busy) check("idle_timeout", 64'd1, 64'd0);
   endtask

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r, input logic dz);
      exp_t e;
      wait_idle();
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      e.a   = a;
      e.b   = b;
      e.q   = q;
      e.r   = r;
      e.dz  = dz;
      e.acc = cyc + 1;
      e.lat = (b == '0) ? LAT_ZERO : LAT_FULL;
      sb.push_back(e);
      @(negedge clock);
      start = 1'b0;
   endtask

   initial begin
      logic [W-1:0] a, b, q, r;
      logic         dz;
      int           done_before;
      int           n;

      reset_n  = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(negedge clock);
      check("rst_lo", outLO, 0);
      check("rst_hi", outHI, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dz", div_zero, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // Directed cases, issued back to back (each new start lands in the
      // previous op's done cycle).
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      issue(-32'sd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      issue(32'd100, -32'sd7, 32'hFFFF_FFF2, 32'd2, 1'b0);
      issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
      issue(32'h8000_0000, 32'd1, 32'h8000_0000, 32'd0, 1'b0);
      issue(32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
      issue(-32'sd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
      issue(32'd7, 32'd100, 32'd0, 32'd7, 1'b0);
      issue(32'd0, 32'd3, 32'd0, 32'd0, 1'b0);
      issue(32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0);
      issue(-32'sd9, -32'sd2, 32'd4, 32'hFFFF_FFFF, 1'b0);

      // Start during busy is dropped; the op in flight still returns 14/2.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (9) @(negedge clock);
      dividend = 32'd9;
      divisor  = 32'd3;
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;

      // Reset in the middle of a second op aborts it without a done pulse.
      issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
      repeat (19) @(negedge clock);
      done_before = done_cnt;
      reset_n = 1'b0;
      #1;
      if (sb.size() > 0) void'(sb.pop_back());
      check("abort_lo", outLO, 0);
      check("abort_hi", outHI, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_dz", div_zero, 0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      repeat (40) @(negedge clock);
      check("abort_no_done", done_cnt, done_before);
      check("abort_idle", busy, 0);

      for (int i = 0; i < NUM_RAND; i++) begin
         a = $urandom;
         b = $urandom;
         if (i % 4 == 0) b = $urandom_range(0, 16) - 8;
         if (i % 50 == 0) a = 32'h8000_0000;
         model(a, b, q, r, dz);
         issue(a, b, q, r, dz);
      end

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
